// File: rtl/pdm_pkg.sv
// Shared types and constants for the PDM-to-PCM CIC decimator.
package pdm_pkg;
  typedef enum logic {WARMUP, RUN} cic_state_t;

  localparam int CIC_ORDER_DEF = 3;
  localparam int CIC_DECIM_DEF = 64;

  // Bit growth of an ORDER-stage CIC at ratio DECIM, plus sign and the +/-1 input.
  function automatic int cic_out_w(input int order, input int decim);
    return order * $clog2(decim) + 2;
  endfunction
endpackage

// File: rtl/pdm_cic_decimator_integrator.sv
// Enable-gated wrapping accumulator: one CIC integrator stage.
module cic_integrator_stage #(
  parameter int W = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] acc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     acc <= '0;
    else if (en) acc <= acc + din;
  end
endmodule

// File: rtl/pdm_cic_decimator.sv
// 1-bit PDM to signed PCM: ORDER integrators at PDM rate, ORDER combs at PCM rate.
module pdm_cic_decimator
  import pdm_pkg::*;
#(
  parameter int ORDER = CIC_ORDER_DEF,
  parameter int DECIM = CIC_DECIM_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  pdm_in,
  input  logic                                  pdm_valid,
  output logic signed [cic_out_w(ORDER,DECIM)-1:0] pcm_data,
  output logic                                  pcm_valid
);
  localparam int OUT_W = cic_out_w(ORDER, DECIM);
  localparam int CNT_W = $clog2(DECIM);

  logic signed [OUT_W-1:0]              x;
  logic        [ORDER-1:0][OUT_W-1:0]   integ;
  logic        [CNT_W-1:0]              cnt;
  logic                                 strobe;
  logic signed [OUT_W-1:0]              cap;
  logic        [ORDER-1:0][OUT_W-1:0]   dly;
  logic        [ORDER:0][OUT_W-1:0]     comb;
  // vld_pipe[0]: comb stage pending, vld_pipe[1]: that pending sample is reportable
  logic        [1:0]                    vld_pipe;
  cic_state_t                           state, state_nxt;
  logic        [2:0]                    disc, disc_nxt;

  assign x = pdm_in ? OUT_W'(1) : {OUT_W{1'b1}};

  for (genvar g = 0; g < ORDER; g++) begin : g_integ
    logic signed [OUT_W-1:0] din;
    if (g == 0) begin : g_first
      assign din = x;
    end else begin : g_chain
      assign din = integ[g-1];
    end
    cic_integrator_stage #(.W(OUT_W)) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (pdm_valid),
      .din (din),
      .acc (integ[g])
    );
  end

  assign strobe = pdm_valid && (cnt == CNT_W'(DECIM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      cap      <= '0;
      vld_pipe <= '0;
    end else begin
      if (pdm_valid) cnt <= cnt + 1'b1;
      if (strobe)    cap <= integ[ORDER-1];
      vld_pipe <= {strobe && (state == RUN), strobe};
    end
  end

  always_comb begin
    comb[0] = cap;
    for (int k = 0; k < ORDER; k++) comb[k+1] = comb[k] - dly[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly       <= '0;
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= vld_pipe[0] && vld_pipe[1];
      if (vld_pipe[0]) begin
        for (int k = 0; k < ORDER; k++) dly[k] <= comb[k];
        if (vld_pipe[1]) pcm_data <= comb[ORDER];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WARMUP;
      disc  <= '0;
    end else begin
      state <= state_nxt;
      disc  <= disc_nxt;
    end
  end

  // The first ORDER+1 comb outputs carry start-up transient and are dropped.
  always_comb begin
    state_nxt = state;
    disc_nxt  = disc;
    if (strobe && state == WARMUP) begin
      if (disc == 3'(ORDER)) begin
        state_nxt = RUN;
        disc_nxt  = '0;
      end else begin
        disc_nxt = disc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed checks of the CIC decimator at default parameters (ORDER=3, DECIM=64).
module tb_pdm_cic_decimator;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pdm_in = 1'b0;
  logic               pdm_valid = 1'b0;
  logic signed [19:0] pcm_data;
  logic               pcm_valid;

  int npass = 0;
  int ntot  = 0;

  localparam logic signed [19:0] FULL_POS = 20'sd262144;
  localparam logic signed [19:0] FULL_NEG = -20'sd262144;
  localparam logic signed [19:0] HALF_POS = 20'sd131072;

  pdm_cic_decimator dut (
    .clk       (clk),
    .rst       (rst),
    .pdm_in    (pdm_in),
    .pdm_valid (pdm_valid),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; pdm_valid = 1'b0; pdm_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // mode 0: all 1s, 1: all 0s, 2: 1,0 alternating, 3: 1,1,1,0 repeating
  task automatic run_stream(input int n, input int mode, input bit gapped,
                            output int npulse, output int first,
                            output logic signed [19:0] dmin, output logic signed [19:0] dmax,
                            output int gmin, output int gmax,
                            output bit consec, output bit pre_nz);
    int k = 0;
    int last = 0;
    bit pv = 1'b0;
    bit b;
    npulse = 0; first = -1; dmin = 20'sh7ffff; dmax = 20'sh80000;
    gmin = 1 << 30; gmax = 0; consec = 1'b0; pre_nz = 1'b0;
    for (int s = 1; s <= n; s++) begin
      case (mode)
        0: b = 1'b1;
        1: b = 1'b0;
        2: b = (k % 2 == 0);
        default: b = (k % 4 != 3);
      endcase
      pdm_valid = gapped ? (s % 2 == 1) : 1'b1;
      pdm_in    = b;
      if (pdm_valid) k++;
      @(posedge clk); #1;
      if (pcm_valid) begin
        if (pv) consec = 1'b1;
        if (first < 0) first = s;
        else begin
          if (s - last < gmin) gmin = s - last;
          if (s - last > gmax) gmax = s - last;
        end
        last = s;
        npulse++;
        if (pcm_data < dmin) dmin = pcm_data;
        if (pcm_data > dmax) dmax = pcm_data;
      end else if (npulse == 0 && pcm_data !== 20'sd0) begin
        pre_nz = 1'b1;
      end
      pv = pcm_valid;
    end
    pdm_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    ntot++; if (pcm_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", pcm_valid); else npass++;
    ntot++; if (pcm_data !== 20'sd0) $display("FAIL reset_data: got %0d want 0", pcm_data); else npass++;
  endtask

  task automatic test_ones();
    int np, fst, gmn, gmx; logic signed [19:0] dmn, dmx; bit cs, pz;
    do_reset();
    run_stream(700, 0, 1'b0, np, fst, dmn, dmx, gmn, gmx, cs, pz);
    ntot++; if (fst !== 321) $display("FAIL ones_first_pulse_cycle: got %0d want 321", fst); else npass++;
    ntot++; if (np !== 6) $display("FAIL ones_pulse_count: got %0d want 6", np); else npass++;
    ntot++; if (dmn !== FULL_POS) $display("FAIL ones_min: got %0d want %0d", dmn, FULL_POS); else npass++;
    ntot++; if (dmx !== FULL_POS) $display("FAIL ones_max: got %0d want %0d", dmx, FULL_POS); else npass++;
    ntot++; if (gmn !== 64 || gmx !== 64) $display("FAIL ones_spacing: got %0d..%0d want 64", gmn, gmx); else npass++;
    ntot++; if (pz !== 1'b0) $display("FAIL ones_warmup_data: got nonzero want 0"); else npass++;
  endtask

  task automatic test_zeros();
    int np, fst, gmn, gmx; logic signed [19:0] dmn, dmx; bit cs, pz;
    do_reset();
    run_stream(700, 1, 1'b0, np, fst, dmn, dmx, gmn, gmx, cs, pz);
    ntot++; if (np !== 6) $display("FAIL zeros_pulse_count: got %0d want 6", np); else npass++;
    ntot++; if (dmn !== FULL_NEG || dmx !== FULL_NEG)
      $display("FAIL zeros_value: got %0d..%0d want %0d", dmn, dmx, FULL_NEG); else npass++;
  endtask

  task automatic test_alternating();
    int np, fst, gmn, gmx; logic signed [19:0] dmn, dmx; bit cs, pz;
    do_reset();
    run_stream(700, 2, 1'b0, np, fst, dmn, dmx, gmn, gmx, cs, pz);
    ntot++; if (np !== 6) $display("FAIL alt_pulse_count: got %0d want 6", np); else npass++;
    ntot++; if (dmn !== 20'sd0 || dmx !== 20'sd0)
      $display("FAIL alt_value: got %0d..%0d want 0", dmn, dmx); else npass++;
  endtask

  task automatic test_pattern();
    int np, fst, gmn, gmx; logic signed [19:0] dmn, dmx; bit cs, pz;
    do_reset();
    run_stream(700, 3, 1'b0, np, fst, dmn, dmx, gmn, gmx, cs, pz);
    ntot++; if (np !== 6) $display("FAIL pattern_pulse_count: got %0d want 6", np); else npass++;
    ntot++; if (dmn !== HALF_POS || dmx !== HALF_POS)
      $display("FAIL pattern_value: got %0d..%0d want %0d", dmn, dmx, HALF_POS); else npass++;
  endtask

  task automatic test_gapped();
    int np, fst, gmn, gmx; logic signed [19:0] dmn, dmx; bit cs, pz;
    do_reset();
    run_stream(1400, 0, 1'b1, np, fst, dmn, dmx, gmn, gmx, cs, pz);
    ntot++; if (fst !== 640) $display("FAIL gap_first_pulse_cycle: got %0d want 640", fst); else npass++;
    ntot++; if (np !== 6) $display("FAIL gap_pulse_count: got %0d want 6", np); else npass++;
    ntot++; if (gmn !== 128 || gmx !== 128) $display("FAIL gap_spacing: got %0d..%0d want 128", gmn, gmx); else npass++;
    ntot++; if (dmn !== FULL_POS || dmx !== FULL_POS)
      $display("FAIL gap_value: got %0d..%0d want %0d", dmn, dmx, FULL_POS); else npass++;
    ntot++; if (cs !== 1'b0) $display("FAIL gap_consecutive: got 1 want 0"); else npass++;
  endtask

  task automatic test_long_wrap();
    int np, fst, gmn, gmx; logic signed [19:0] dmn, dmx; bit cs, pz;
    do_reset();
    run_stream(20000, 0, 1'b0, np, fst, dmn, dmx, gmn, gmx, cs, pz);
    ntot++; if (np !== 308) $display("FAIL long_pulse_count: got %0d want 308", np); else npass++;
    ntot++; if (dmn !== FULL_POS || dmx !== FULL_POS)
      $display("FAIL long_value: got %0d..%0d want %0d", dmn, dmx, FULL_POS); else npass++;
  endtask

  task automatic test_mid_reset();
    int np, fst, gmn, gmx; logic signed [19:0] dmn, dmx; bit cs, pz;
    int seen = 0;
    int steps = 0;
    do_reset();
    pdm_valid = 1'b1; pdm_in = 1'b1;
    while (seen < 2 && steps < 2000) begin
      @(posedge clk); #1;
      steps++;
      if (pcm_valid) seen++;
    end
    ntot++; if (seen !== 2) $display("FAIL midrst_reach_run: got %0d pulses want 2", seen); else npass++;
    rst = 1'b1;
    #1;
    ntot++; if (pcm_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", pcm_valid); else npass++;
    ntot++; if (pcm_data !== 20'sd0) $display("FAIL midrst_data: got %0d want 0", pcm_data); else npass++;
    pdm_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    run_stream(400, 0, 1'b0, np, fst, dmn, dmx, gmn, gmx, cs, pz);
    ntot++; if (fst !== 321) $display("FAIL midrst_first_pulse_cycle: got %0d want 321", fst); else npass++;
    ntot++; if (dmn !== FULL_POS) $display("FAIL midrst_value: got %0d want %0d", dmn, FULL_POS); else npass++;
  endtask

  initial begin
    test_reset();
    test_ones();
    test_zeros();
    test_alternating();
    test_pattern();
    test_gapped();
    test_long_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/pdm_cic_decimator.md
# pdm_cic_decimator

Converts a 1-bit PDM microphone bitstream into signed multi-bit PCM samples with an ORDER-stage CIC decimator (integrators at PDM rate, combs at PCM rate). Sits directly downstream of the PDM source, either the file-driven PDM stimulus in simulation or the microphone capture in hardware, and feeds the equalizer filter bank. There is no backpressure: every produced PCM sample is presented for exactly one cycle.

## Interface
Parameters:
- ORDER, default 3: number of integrator and comb stages; legal range 1..5.
- DECIM, default 64: decimation ratio; must be a power of two and at least 4.
- OUT_W (localparam), value ORDER*$clog2(DECIM)+2: PCM and accumulator width. Default is 20.

Ports:
- clk, in, 1: single clock for the whole block.
- rst, in, 1: reset, asynchronous and active-high; clears all state.
- pdm_in, in, 1: PDM bit. 1 maps to +1 and 0 maps to −1.
- pdm_valid, in, 1: pdm_in is sampled on a rising clk edge only when this is high. Gaps of any length are legal.
- pcm_data, out, signed [OUT_W-1:0]: decimated sample. It holds its value between pulses.
- pcm_valid, out, 1: one-cycle pulse marking a new pcm_data.

## Operation
- **Input mapping:** the mapped value x is ±1, sign-extended to OUT_W.
- **Integrators:** ORDER cascaded registered accumulators, all OUT_W wide, using modular (wrapping) two's-complement arithmetic. They update only when pdm_valid=1.
  - Stage 0 computes I0 += x.
  - Stage k computes Ik += I(k−1), using the registered value.
- **Decimation counter:** $clog2(DECIM) bits, increments on each valid input. A strobe fires on the valid input at which the counter equals DECIM−1, and the counter then wraps to 0.
- **Combs:** on the strobe cycle, the last integrator's value is captured. In the following cycle, ORDER differences with delay 1 (at PCM rate) are computed combinationally and registered into pcm_data. Each comb's delay register updates only on strobe. Arithmetic is modular.
- **State machine:** states are WARMUP and RUN.
  - WARMUP: a discard counter counts strobes. The first ORDER+1 comb outputs update the internal comb state but do not assert pcm_valid, and pcm_data stays at 0. On the (ORDER+1)th strobe the FSM moves to RUN.
  - RUN: every comb output asserts pcm_valid.
- **Gain:** DECIM^ORDER. Full scale is ±2^18 at the defaults and fits in OUT_W without saturation logic.

## Timing
- Reset values: pcm_data=0, pcm_valid=0, all integrators, combs and counters at 0, FSM in WARMUP.
- Latency: pcm_valid rises at the clk edge after the edge that accepted the DECIMth valid input of a frame.
- Output spacing: pcm_valid never asserts on two consecutive cycles, and pulses are at least DECIM valid inputs apart.
- pdm_valid low on a strobe-pending cycle: nothing advances, and the strobe waits for the next valid input.
- Reset asserted mid-frame or mid-pulse: all state clears immediately (asynchronously), and pcm_valid drops in the same cycle. After release the block restarts in WARMUP with the counter at 0.
- Integrator wrap-around is expected and correct. The comb differences recover exact values for any input length.

## Structure
- Package pdm_pkg holds:
  - the typedef enum logic {WARMUP, RUN} cic_state_t;
  - the default constants CIC_ORDER_DEF=3 and CIC_DECIM_DEF=64;
  - the function cic_out_w(order, decim), used for OUT_W.
- One sub-module, cic_integrator_stage: a parameterized width, enable-gated wrapping accumulator, instantiated ORDER times in a generate loop.
- The combs stay inline in pdm_cic_decimator.

## Test plan
- Constant 1s, pdm_valid held high from reset → no pcm_valid for the first 4 frames. The 5th pulse, at valid input #320 + 1 cycle, has pcm_data=+262144, and every later pulse equals the same value.
- Constant 0s → steady-state pcm_data=−262144. Alternating 1,0 → steady-state pcm_data=0.
- pdm_valid toggling 1,0 with constant 1s → same values as the all-1s case, pulses 128 cycles apart, and pcm_valid is never high on two consecutive cycles.
- Run for 10^6 inputs of 1s (integrators wrap many times) → every output stays exactly +262144.
- Assert rst during a frame in RUN → pcm_valid=0 and pcm_data=0 immediately. After release, 5 strobes pass before the next pcm_valid.
- Sine-density PDM stream taken from the file stimulus (30k samples) → the PCM sequence matches the bit-exact Python CIC model.
